uart_transmit: RTL and testbench

Serialising UART transmitter that produces 8N1 or 8N2 frames (start bit, eight data bits LSB first, one or two stop bits). It runs in the bit-rate clock domain: one `sys_clk` cycle per bit, with no oversampling. Bytes arrive over a ready/valid-style write port and are buffered in a small FIFO, so back-to-back frames go out with no idle gap. It is the transmit counterpart of `uart_receive`, and its frames are sampled correctly by that block on the same clock.

---
 rtl/uart_transmit.sv | 140 ++++++++++++++
 tb/tb_uart_transmit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// UART transmitter (8N1/8N2), one clock per bit, fed by a small byte FIFO.
// Frames are emitted back to back while the FIFO holds data.
module uart_transmit #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       sys_clk,
    input  logic       sys_reset,
    input  logic [7:0] i_send_data,
    input  logic       i_send_data_en,
    output logic       o_send_ready,
    output logic       o_busy,
    output logic       o_send_done,
    output logic       uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [0:0]    stop_cnt_q, stop_cnt_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          push;
    logic          pop;
    logic          fifo_empty;

    assign o_send_ready = (count_q != CW'(FIFO_DEPTH));
    assign o_busy       = (state_q != IDLE) || (count_q != '0);
    assign o_send_done  = done_q;
    assign uart_tx      = tx_q;

    // tx_d is the line level for the state being entered, so uart_tx stays registered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        push       = i_send_data_en && o_send_ready;
        fifo_empty = (count_q == '0);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                state_d   = DATA;
                bit_cnt_d = 3'd0;
                tx_d      = shift_q[0];
            end
            DATA: begin
                if (bit_cnt_q == 3'd7) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    tx_d      = shift_q[1];
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_send_data;
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: one DUT with one stop bit, one with two,
// plus a line decoder acting as the receiving end of dut1.
module tb_uart_transmit;
  logic clk = 1'b0;
  logic rst;
  logic en1, en2;
  logic [7:0] d1, d2;
  logic ready1, busy1, done1, tx1;
  logic ready2, busy2, done2, tx2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base;
  int frame_err = 0;

  logic tx1_log [4096];
  logic done1_log [4096];
  logic busy1_log [4096];
  logic tx2_log [4096];
  logic done2_log [4096];

  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  logic [2:0] rx_n;
  int rx_st = 0;

  uart_transmit #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .sys_clk(clk), .sys_reset(rst), .i_send_data(d1), .i_send_data_en(en1),
    .o_send_ready(ready1), .o_busy(busy1), .o_send_done(done1), .uart_tx(tx1)
  );

  uart_transmit #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .sys_clk(clk), .sys_reset(rst), .i_send_data(d2), .i_send_data_en(en2),
    .o_send_ready(ready2), .o_busy(busy2), .o_send_done(done2), .uart_tx(tx2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // per-cycle log and serial decoder; value after edge E+k lands at index base+k
  always @(negedge clk) begin
    cyc++;
    if (cyc < 4096) begin
      tx1_log[cyc] = tx1;
      done1_log[cyc] = done1;
      busy1_log[cyc] = busy1;
      tx2_log[cyc] = tx2;
      done2_log[cyc] = done2;
    end
    if (rst) begin
      rx_st = 0;
    end else begin
      case (rx_st)
        0: if (!tx1) begin rx_st = 1; rx_n = 3'd0; end
        1: begin
          rx_byte[rx_n] = tx1;
          if (rx_n == 3'd7) rx_st = 2;
          else rx_n = rx_n + 3'd1;
        end
        default: begin
          if (tx1) rx_q.push_back(rx_byte);
          else frame_err++;
          rx_st = 0;
        end
      endcase
    end
  end

  task automatic test_reset;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; d1 = 8'h00; d2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done1 got=%b exp=0", done1); end
    checks++; if (tx2 !== 1'b1) begin failures++; $display("FAIL reset_tx2 got=%b exp=1", tx2); end
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%b exp=0", busy2); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame;
    logic [9:0] exp_tx;
    exp_tx = 10'b1101001010;
    rx_q.delete();
    d1 = 8'hA5; en1 = 1'b1;
    @(posedge clk); #1;
    en1 = 1'b0; d1 = 8'h00;
    base = cyc + 1;
    repeat (14) @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      checks++; if (tx1_log[base+k] !== exp_tx[k-1]) begin failures++;
        $display("FAIL single_tx E+%0d got=%b exp=%b", k, tx1_log[base+k], exp_tx[k-1]); end
      checks++; if (busy1_log[base+k] !== 1'b1) begin failures++;
        $display("FAIL single_busy E+%0d got=%b exp=1", k, busy1_log[base+k]); end
      checks++; if (done1_log[base+k] !== 1'b0) begin failures++;
        $display("FAIL single_done_early E+%0d got=%b exp=0", k, done1_log[base+k]); end
    end
    checks++; if (done1_log[base+11] !== 1'b1) begin failures++;
      $display("FAIL single_done E+11 got=%b exp=1", done1_log[base+11]); end
    checks++; if (busy1_log[base+11] !== 1'b0) begin failures++;
      $display("FAIL single_busy_fall E+11 got=%b exp=0", busy1_log[base+11]); end
    checks++; if (tx1_log[base+11] !== 1'b1) begin failures++;
      $display("FAIL single_idle_tx E+11 got=%b exp=1", tx1_log[base+11]); end
    checks++; if (done1_log[base+12] !== 1'b0) begin failures++;
      $display("FAIL single_done_width E+12 got=%b exp=0", done1_log[base+12]); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin failures++;
      $display("FAIL single_rx size=%0d exp_size=1 exp_data=a5", rx_q.size()); end
  endtask

  task automatic test_fifo_full;
    int dones;
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      d1 = 8'(i + 1); en1 = 1'b1;
      @(posedge clk); #1;
      if (i == 0) base = cyc + 1;
      checks++; if (ready1 !== (i < 4)) begin failures++;
        $display("FAIL full_ready write%0d got=%b exp=%b", i + 1, ready1, (i < 4)); end
    end
    en1 = 1'b0;
    repeat (55) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (tx1_log[base+1+10*k] !== 1'b0) begin failures++;
        $display("FAIL full_start frame%0d got=%b exp=0", k, tx1_log[base+1+10*k]); end
      checks++; if (tx1_log[base+10+10*k] !== 1'b1) begin failures++;
        $display("FAIL full_stop frame%0d got=%b exp=1", k, tx1_log[base+10+10*k]); end
      checks++; if (done1_log[base+11+10*k] !== 1'b1) begin failures++;
        $display("FAIL full_done frame%0d got=%b exp=1", k, done1_log[base+11+10*k]); end
    end
    dones = 0;
    for (int k = 0; k <= 54; k++) if (done1_log[base+k] === 1'b1) dones++;
    checks++; if (dones != 5) begin failures++;
      $display("FAIL full_done_count got=%0d exp=5", dones); end
    checks++; if (rx_q.size() != 5) begin failures++;
      $display("FAIL full_rx_count got=%0d exp=5", rx_q.size()); end
    for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== 8'(k + 1)) begin failures++;
        $display("FAIL full_rx_data idx%0d got=%h exp=%h", k, rx_q[k], 8'(k + 1)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    int dones;
    exp_b[0] = 8'h3C; exp_b[1] = 8'hFF; exp_b[2] = 8'h00;
    rx_q.delete();
    frame_err = 0;
    for (int i = 0; i < 3; i++) begin
      d1 = exp_b[i]; en1 = 1'b1;
      @(posedge clk); #1;
      if (i == 0) base = cyc + 1;
    end
    en1 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 3) begin failures++;
      $display("FAIL loop_rx_count got=%0d exp=3", rx_q.size()); end
    for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_b[k]) begin failures++;
        $display("FAIL loop_rx_data idx%0d got=%h exp=%h", k, rx_q[k], exp_b[k]); end
    end
    checks++; if (frame_err != 0) begin failures++;
      $display("FAIL loop_framing got=%0d exp=0", frame_err); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (tx1_log[base+1+10*k] !== 1'b0) begin failures++;
        $display("FAIL loop_start frame%0d got=%b exp=0", k, tx1_log[base+1+10*k]); end
    end
    dones = 0;
    for (int k = 0; k <= 39; k++) if (done1_log[base+k] === 1'b1) dones++;
    checks++; if (dones != 3) begin failures++;
      $display("FAIL loop_done_count got=%0d exp=3", dones); end
  endtask

  task automatic test_two_stop;
    logic exp_bit;
    int dones;
    for (int i = 0; i < 2; i++) begin
      d2 = 8'h80; en2 = 1'b1;
      @(posedge clk); #1;
      if (i == 0) base = cyc + 1;
    end
    en2 = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    // 0x80: start, seven 0s, a 1, two stop bits, then frame 2 starts at E+12
    for (int k = 1; k <= 23; k++) begin
      exp_bit = ((k >= 9) && (k <= 11)) || (k >= 20);
      checks++; if (tx2_log[base+k] !== exp_bit) begin failures++;
        $display("FAIL stop2_tx E+%0d got=%b exp=%b", k, tx2_log[base+k], exp_bit); end
    end
    checks++; if (done2_log[base+12] !== 1'b1) begin failures++;
      $display("FAIL stop2_done1 E+12 got=%b exp=1", done2_log[base+12]); end
    checks++; if (done2_log[base+23] !== 1'b1) begin failures++;
      $display("FAIL stop2_done2 E+23 got=%b exp=1", done2_log[base+23]); end
    dones = 0;
    for (int k = 0; k <= 27; k++) if (done2_log[base+k] === 1'b1) dones++;
    checks++; if (dones != 2) begin failures++;
      $display("FAIL stop2_done_count got=%0d exp=2", dones); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] bytes [3];
    int bad;
    bytes[0] = 8'h55; bytes[1] = 8'h0F; bytes[2] = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      d1 = bytes[i]; en1 = 1'b1;
      @(posedge clk); #1;
    end
    en1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx1 !== 1'b0) begin failures++;
      $display("FAIL midrst_bit3 got=%b exp=0", tx1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (tx1 !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy1); end
    checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done1); end
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (tx1 !== 1'b1 || done1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL midrst_quiet bad_cycles=%0d exp=0", bad); end
    rx_q.delete();
  endtask

  task automatic test_push_pop;
    logic [7:0] exp_b [6];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
    rx_q.delete();
    frame_err = 0;
    for (int i = 0; i < 5; i++) begin
      d1 = exp_b[i]; en1 = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready1 !== (i != 4)) begin failures++;
        $display("FAIL pp_ready write%0d got=%b exp=%b", i + 1, ready1, (i != 4)); end
    end
    en1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (ready1 !== 1'b0) begin failures++;
      $display("FAIL pp_full_before_pop got=%b exp=0", ready1); end
    d1 = 8'h77; en1 = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready1 !== 1'b1) begin failures++;
      $display("FAIL pp_after_pop_drop got=%b exp=1", ready1); end
    d1 = 8'h66;
    @(posedge clk); #1;
    en1 = 1'b0;
    checks++; if (ready1 !== 1'b0) begin failures++;
      $display("FAIL pp_refull got=%b exp=0", ready1); end
    repeat (70) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 6) begin failures++;
      $display("FAIL pp_rx_count got=%0d exp=6", rx_q.size()); end
    for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_b[k]) begin failures++;
        $display("FAIL pp_rx_data idx%0d got=%h exp=%h", k, rx_q[k], exp_b[k]); end
    end
    checks++; if (busy1 !== 1'b0) begin failures++;
      $display("FAIL pp_final_idle got=%b exp=0", busy1); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fifo_full();
    test_back_to_back();
    test_two_stop();
    test_reset_mid_frame();
    test_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
